bsg_dramsim3_req_throttle_monitor: RTL
======================================

// Module: bsg_dramsim3_req_throttle_monitor
// PURPOSE
//  Sits between a request source (trace replay, core) and one bsg_nonsynth_dramsim3 channel.
//  Caps outstanding requests and blocks a read to an address that already has a read in flight.
//  Tracks in-flight reads in a small address table and measures per-read latency.
//  Exports issue/retire counters for bandwidth and latency characterisation.
// PARAMETERS
//  channel_addr_width_p  29   DRAM channel address width (from dram pkg)
//  data_width_p          512  DRAM data width (from dram pkg)
//  max_reads_p           8    read-tracking table entries (max in-flight reads)
//  max_outstanding_p     16   cap on reads+writes in flight
//  counter_width_p       32   width of cycle stamp and issue/retire counters
//  lat_sum_width_p       48   width of latency accumulator
// PORTS
//  clk                clk  in   1   clock
//  reset              reset in  1   synchronous, active-high
//  clear_i            in   1    zero all statistics outputs; table and credits untouched
//  v_i                in   1    upstream request valid
//  write_not_read_i   in   1    1=write, 0=read
//  ch_addr_i          in   CAW  request channel address
//  data_v_i           in   1    write data valid (must equal v_i&write_not_read_i)
//  data_i             in   DW   write data
//  yumi_o             out  1    upstream request accepted this cycle
//  v_o                out  1    request valid to dramsim3
//  write_not_read_o   out  1    passthrough
//  ch_addr_o          out  CAW  passthrough
//  data_v_o           out  1    v_o & write_not_read_i
//  data_o             out  DW   passthrough
//  yumi_i             in   1    dramsim3 accepted request
//  dram_data_v_i      in   1    read data returned
//  dram_read_done_ch_addr_i in CAW  address of returned read
//  dram_write_done_i  in   1    write retired
//  outstanding_o      out  $clog2(max_outstanding_p+1)  current in-flight count
//  reads_issued_o / writes_issued_o / reads_done_o / writes_done_o  out counter_width_p
//  lat_sum_o          out  lat_sum_width_p  sum of read latencies, saturating
//  lat_max_o          out  counter_width_p  largest read latency seen
//  error_o            out  1    sticky: unmatched read return or credit underflow
// BEHAVIOUR
//  - Reset: table all invalid, outstanding 0, cycle stamp 0, all counters/stats 0, error_o 0.
//  - Issue gate: v_o = v_i & (outstanding < max_outstanding_p) &
//    (write | (free table entry & no valid entry with addr==ch_addr_i)). v_o never depends on yumi_i.
//  - yumi_o = v_o & yumi_i. Zero-cycle passthrough of addr/data/wnr.
//  - Read accept: allocate lowest-index free entry {valid, addr, stamp=cycle_r}.
//  - Read return: CAM-match addr among valid entries; exactly one match guaranteed by duplicate block.
//    Free entry, latency = cycle_r - stamp (mod 2^counter_width_p), add to lat_sum (saturate at all-ones),
//    update lat_max. No match -> error_o set, no table change.
//  - Entry freed in cycle N is allocatable in N+1 (the free mask is registered).
//  - outstanding_o += accept; -= dram_data_v_i, -= dram_write_done_i (net of all 3 in one cycle).
//    Decrement below 0 -> error_o set and count held at 0.
//  - Read return and write done in the same cycle: both counted; both retire.
//  - clear_i and an event in the same cycle: clear wins, the event is dropped from the stats.
//  - Counters wrap; cycle_r is free-running from reset.
//  - Reset mid-operation: all state discarded; late returns after reset then raise error_o.
// STRUCTURE
//  - bsg_dramsim3_monitor_pkg: read_entry_s {v, ch_addr, stamp}; stat widths.
//  - Sub-module bsg_dram_read_tag_table: alloc (priority-encoded free slot), CAM lookup, retire,
//    full/hit outputs. Top holds credits, counters and stats.
// TESTING
//  1 single read at 0x40, dramsim returns after 37 cycles -> reads_done=1, lat_sum=37, lat_max=37.
//  2 9 reads to distinct addrs, max_reads_p=8, no returns -> 8 issued, 9th has v_o=0 until a return.
//  3 read 0x80 in flight, second read 0x80 -> v_o=0 until the first returns; issues the next cycle.
//  4 16 writes with no write_done -> 17th write blocked; one write_done -> 17th issues; outstanding_o=16.
//  5 dram_data_v_i with addr 0x1000 not in the table -> error_o=1 sticky; counters unchanged.
//  6 clear_i with a return in the same cycle -> all stats 0; outstanding_o still decrements.

Source files
------------

// File: rtl/bsg_dramsim3_monitor_pkg.sv
// Shared types and default widths for the dramsim3 request throttle/monitor.
// Widths default to the DRAM channel configuration used by bsg_nonsynth_dramsim3.
package bsg_dramsim3_monitor_pkg;

   localparam int dram_channel_addr_width_gp = 29;
   localparam int dram_data_width_gp         = 512;
   localparam int counter_width_gp           = 32;
   localparam int lat_sum_width_gp           = 48;

   typedef struct packed {
      logic                                  v;
      logic [dram_channel_addr_width_gp-1:0] ch_addr;
      logic [counter_width_gp-1:0]           stamp;
   } read_entry_s;

   typedef struct packed {
      logic read_accept;
      logic write_accept;
      logic read_retire;
      logic write_retire;
   } stat_event_s;

endpackage

// File: rtl/bsg_dram_read_tag_table.sv
// In-flight read table: lowest-free-slot allocation, CAM lookup for duplicate
// blocking, and CAM retire that hands back the issue stamp of the matching read.
module bsg_dram_read_tag_table
   import bsg_dramsim3_monitor_pkg::*;
   #(parameter int els_p = 8)
   (input  logic                                  clk
   ,input  logic                                  reset
   ,input  logic                                  alloc_v_i
   ,input  logic [dram_channel_addr_width_gp-1:0] alloc_addr_i
   ,input  logic [counter_width_gp-1:0]           alloc_stamp_i
   ,input  logic [dram_channel_addr_width_gp-1:0] lookup_addr_i
   ,output logic                                  full_o
   ,output logic                                  hit_o
   ,input  logic                                  retire_v_i
   ,input  logic [dram_channel_addr_width_gp-1:0] retire_addr_i
   ,output logic                                  retire_hit_o
   ,output logic [counter_width_gp-1:0]           retire_stamp_o
   );

   read_entry_s [els_p-1:0] entries_r;
   logic [els_p-1:0] valid, free_mask, alloc_onehot, lookup_match, retire_match;

   // Free mask comes straight from registered valids, so a slot retired this
   // cycle only becomes allocatable next cycle.
   always_comb begin
      valid          = '0;
      lookup_match   = '0;
      retire_match   = '0;
      retire_stamp_o = '0;
      for (int i = 0; i < els_p; i++) begin
         valid[i]        = entries_r[i].v;
         lookup_match[i] = entries_r[i].v && (entries_r[i].ch_addr == lookup_addr_i);
         retire_match[i] = entries_r[i].v && (entries_r[i].ch_addr == retire_addr_i);
         if (retire_match[i]) retire_stamp_o = retire_stamp_o | entries_r[i].stamp;
      end
      free_mask    = ~valid;
      alloc_onehot = free_mask & (~free_mask + els_p'(1));
   end

   assign full_o       = &valid;
   assign hit_o        = |lookup_match;
   assign retire_hit_o = |retire_match;

   always_ff @(posedge clk) begin
      if (reset) begin
         entries_r <= '0;
      end else begin
         for (int i = 0; i < els_p; i++) begin
            if (retire_v_i && retire_match[i]) entries_r[i].v <= 1'b0;
            if (alloc_v_i && alloc_onehot[i]) begin
               entries_r[i].v       <= 1'b1;
               entries_r[i].ch_addr <= alloc_addr_i;
               entries_r[i].stamp   <= alloc_stamp_i;
            end
         end
      end
   end

endmodule

// File: rtl/bsg_dramsim3_req_throttle_monitor.sv
// Request throttle between a request source and one dramsim3 channel: caps
// outstanding requests, blocks duplicate in-flight reads and gathers latency stats.
module bsg_dramsim3_req_throttle_monitor
   import bsg_dramsim3_monitor_pkg::*;
   #(parameter  int channel_addr_width_p = dram_channel_addr_width_gp
    ,parameter  int data_width_p         = dram_data_width_gp
    ,parameter  int max_reads_p          = 8
    ,parameter  int max_outstanding_p    = 16
    ,parameter  int counter_width_p      = counter_width_gp
    ,parameter  int lat_sum_width_p      = lat_sum_width_gp
    ,localparam int out_width_lp         = $clog2(max_outstanding_p+1)
    )
   (input  logic                            clk
   ,input  logic                            reset
   ,input  logic                            clear_i
   ,input  logic                            v_i
   ,input  logic                            write_not_read_i
   ,input  logic [channel_addr_width_p-1:0] ch_addr_i
   ,input  logic                            data_v_i
   ,input  logic [data_width_p-1:0]         data_i
   ,output logic                            yumi_o
   ,output logic                            v_o
   ,output logic                            write_not_read_o
   ,output logic [channel_addr_width_p-1:0] ch_addr_o
   ,output logic                            data_v_o
   ,output logic [data_width_p-1:0]         data_o
   ,input  logic                            yumi_i
   ,input  logic                            dram_data_v_i
   ,input  logic [channel_addr_width_p-1:0] dram_read_done_ch_addr_i
   ,input  logic                            dram_write_done_i
   ,output logic [out_width_lp-1:0]         outstanding_o
   ,output logic [counter_width_p-1:0]      reads_issued_o
   ,output logic [counter_width_p-1:0]      writes_issued_o
   ,output logic [counter_width_p-1:0]      reads_done_o
   ,output logic [counter_width_p-1:0]      writes_done_o
   ,output logic [lat_sum_width_p-1:0]      lat_sum_o
   ,output logic [counter_width_p-1:0]      lat_max_o
   ,output logic                            error_o
   );

   localparam int out_ext_lp = out_width_lp + 1;
   localparam int sum_ext_lp = lat_sum_width_p + 1;

   logic [counter_width_p-1:0] cycle_r, ret_stamp, lat;
   logic [out_width_lp-1:0]    outstanding_r, outstanding_next;
   logic [out_ext_lp-1:0]      out_plus, out_dec;
   logic [sum_ext_lp-1:0]      lat_sum_ext;
   logic                       tbl_full, tbl_hit, ret_hit, credit_ok, underflow, unmatched;
   logic                       error_r;
   logic                       unused_data_v;
   stat_event_s                ev;

   assign unused_data_v = data_v_i;

   // Handshake: v_o is offered from upstream v_i and local credit/table state
   // only; the request transfers on v_o & yumi_i, which is echoed upstream as yumi_o.
   assign credit_ok        = outstanding_r < out_width_lp'(max_outstanding_p);
   assign v_o              = v_i & credit_ok & (write_not_read_i | (~tbl_full & ~tbl_hit));
   assign yumi_o           = v_o & yumi_i;
   assign write_not_read_o = write_not_read_i;
   assign ch_addr_o        = ch_addr_i;
   assign data_v_o         = v_o & write_not_read_i;
   assign data_o           = data_i;

   bsg_dram_read_tag_table #(.els_p(max_reads_p)) tag_table
      (.clk            (clk)
      ,.reset          (reset)
      ,.alloc_v_i      (ev.read_accept)
      ,.alloc_addr_i   (ch_addr_i)
      ,.alloc_stamp_i  (cycle_r)
      ,.lookup_addr_i  (ch_addr_i)
      ,.full_o         (tbl_full)
      ,.hit_o          (tbl_hit)
      ,.retire_v_i     (dram_data_v_i)
      ,.retire_addr_i  (dram_read_done_ch_addr_i)
      ,.retire_hit_o   (ret_hit)
      ,.retire_stamp_o (ret_stamp)
      );

   always_comb begin
      ev              = '0;
      ev.read_accept  = yumi_o & ~write_not_read_i;
      ev.write_accept = yumi_o &  write_not_read_i;
      ev.read_retire  = dram_data_v_i & ret_hit;
      ev.write_retire = dram_write_done_i;
      unmatched       = dram_data_v_i & ~ret_hit;

      out_plus         = {1'b0, outstanding_r} + out_ext_lp'(yumi_o);
      out_dec          = out_ext_lp'(dram_data_v_i) + out_ext_lp'(dram_write_done_i);
      underflow        = out_plus < out_dec;
      outstanding_next = underflow ? '0 : out_width_lp'(out_plus - out_dec);

      lat         = cycle_r - ret_stamp;
      lat_sum_ext = {1'b0, lat_sum_o} + sum_ext_lp'(lat);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_r       <= '0;
         outstanding_r <= '0;
         error_r       <= 1'b0;
      end else begin
         cycle_r       <= cycle_r + counter_width_p'(1);
         outstanding_r <= outstanding_next;
         if (underflow | unmatched) error_r <= 1'b1;
      end
   end

   // Statistics only; clear drops whatever events land in the same cycle.
   always_ff @(posedge clk) begin
      if (reset | clear_i) begin
         reads_issued_o  <= '0;
         writes_issued_o <= '0;
         reads_done_o    <= '0;
         writes_done_o   <= '0;
         lat_sum_o       <= '0;
         lat_max_o       <= '0;
      end else begin
         reads_issued_o  <= reads_issued_o  + counter_width_p'(ev.read_accept);
         writes_issued_o <= writes_issued_o + counter_width_p'(ev.write_accept);
         reads_done_o    <= reads_done_o    + counter_width_p'(ev.read_retire);
         writes_done_o   <= writes_done_o   + counter_width_p'(ev.write_retire);
         if (ev.read_retire) begin
            lat_sum_o <= lat_sum_ext[lat_sum_width_p] ? '1 : lat_sum_ext[lat_sum_width_p-1:0];
            if (lat > lat_max_o) lat_max_o <= lat;
         end
      end
   end

   assign outstanding_o = outstanding_r;
   assign error_o       = error_r;

endmodule
